orv64_icache_resp: RTL and testbench



---
 rtl/orv64_icache_resp.sv | 164 ++++++++++++++++
 tb/tb_orv64_icache_resp.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/orv64_icache_resp.sv
// orv64_icache_resp: responder end of the instruction-buffer / I$ line-fetch
// protocol. A small direct-mapped, flop-based L1 I$ backed by a
// single-outstanding L2 fill port. Translation is bare.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   ib2ic_en/_pc       line request (held until ic2ib_valid)
//   ic2ib_*            one-cycle line response, exception flag/cause, paddr
//   l1_hit, l1_miss    response source pulses
//   ic_flush           fence.i, invalidate all lines
//   ic2l2_req_*        fill request (valid/ready, line-aligned paddr)
//   l22ic_resp_*       single-beat fill response with bus error
//   ic_idle            FSM idle, nothing outstanding

package orv64_icache_resp_pkg;
  typedef enum logic [3:0] {
    ORV64_EXCP_CAUSE_INST_ADDR_MISALIGNED = 4'd0,
    ORV64_EXCP_CAUSE_INST_ACCESS_FAULT    = 4'd1,
    ORV64_EXCP_CAUSE_ILLEGAL_INST         = 4'd2,
    ORV64_EXCP_CAUSE_BREAKPOINT           = 4'd3
  } orv64_excp_cause_t;
endpackage

module orv64_icache_resp
  import orv64_icache_resp_pkg::*;
#(
  parameter int NUM_SETS     = 8,
  parameter int LINE_WIDTH   = 256,
  parameter int OFFSET_WIDTH = 5,
  parameter int VADDR_WIDTH  = 39,
  parameter int PADDR_WIDTH  = 56
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ib2ic_en,
  input  logic [VADDR_WIDTH-1:0]  ib2ic_pc,
  output logic                    ic2ib_valid,
  output logic [LINE_WIDTH-1:0]   ic2ib_rdata,
  output logic                    ic2ib_excp_valid,
  output orv64_excp_cause_t       ic2ib_excp_cause,
  output logic [PADDR_WIDTH-1:0]  ic2ib_pc_paddr,
  output logic                    l1_hit,
  output logic                    l1_miss,
  input  logic                    ic_flush,
  output logic                    ic2l2_req_valid,
  input  logic                    ic2l2_req_ready,
  output logic [PADDR_WIDTH-1:0]  ic2l2_req_paddr,
  input  logic                    l22ic_resp_valid,
  input  logic [LINE_WIDTH-1:0]   l22ic_resp_data,
  input  logic                    l22ic_resp_err,
  output logic                    ic_idle
);

  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int LINE_W = VADDR_WIDTH - OFFSET_WIDTH;
  localparam int TAG_W  = LINE_W - IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_FILL_REQ,
    ST_FILL_WAIT
  } state_t;

  state_t                  state;
  logic                    flush_pend;
  logic [LINE_W-1:0]       req_line;   // pc with the byte offset stripped
  logic [NUM_SETS-1:0]     valid;
  logic [TAG_W-1:0]        tag_arr  [NUM_SETS];
  logic [LINE_WIDTH-1:0]   data_arr [NUM_SETS];

  logic [IDX_W-1:0]        req_idx;
  logic [TAG_W-1:0]        req_tag;
  logic [PADDR_WIDTH-1:0]  req_paddr;
  logic                    hit;
  logic                    lookup_hit;
  logic                    fill_done;
  logic                    install;
  logic                    unused_pc_offset;

  assign unused_pc_offset = ^ib2ic_pc[OFFSET_WIDTH-1:0];

  assign req_idx   = req_line[IDX_W-1:0];
  assign req_tag   = req_line[LINE_W-1:IDX_W];
  // Bare translation: zero-extend or truncate the aligned pc to paddr width.
  assign req_paddr = PADDR_WIDTH'({req_line, {OFFSET_WIDTH{1'b0}}});

  assign hit        = valid[req_idx] && (tag_arr[req_idx] == req_tag);
  assign lookup_hit = (state == ST_LOOKUP) && hit;
  assign fill_done  = (state == ST_FILL_WAIT) && l22ic_resp_valid;
  // A flush seen at any point during the fill (or in the return cycle)
  // means the returning line may be stale, so it is delivered but not kept.
  assign install    = fill_done && !l22ic_resp_err && !flush_pend && !ic_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      flush_pend <= 1'b0;
      valid      <= '0;
      req_line   <= '0;
    end else begin
      if (ic_flush) begin
        valid <= '0;
      end else if (install) begin
        valid[req_idx] <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          flush_pend <= 1'b0;
          if (ib2ic_en) begin
            req_line <= ib2ic_pc[VADDR_WIDTH-1:OFFSET_WIDTH];
            state    <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          state <= hit ? ST_IDLE : ST_FILL_REQ;
        end
        ST_FILL_REQ: begin
          if (ic_flush) flush_pend <= 1'b1;
          if (ic2l2_req_ready) state <= ST_FILL_WAIT;
        end
        ST_FILL_WAIT: begin
          if (l22ic_resp_valid) begin
            state      <= ST_IDLE;
            flush_pend <= 1'b0;
          end else if (ic_flush) begin
            flush_pend <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; only the valid bits do.
  always_ff @(posedge clk) begin
    if (install) begin
      tag_arr[req_idx]  <= req_tag;
      data_arr[req_idx] <= l22ic_resp_data;
    end
  end

  always_comb begin
    ic2ib_rdata = '0;
    if (lookup_hit) begin
      ic2ib_rdata = data_arr[req_idx];
    end else if (fill_done && !l22ic_resp_err) begin
      ic2ib_rdata = l22ic_resp_data;
    end
  end

  assign ic2ib_valid      = lookup_hit || fill_done;
  assign l1_hit           = lookup_hit;
  assign l1_miss          = fill_done;
  assign ic2ib_excp_valid = fill_done && l22ic_resp_err;
  assign ic2ib_excp_cause = ic2ib_excp_valid ? ORV64_EXCP_CAUSE_INST_ACCESS_FAULT
                                             : ORV64_EXCP_CAUSE_INST_ADDR_MISALIGNED;
  assign ic2ib_pc_paddr   = req_paddr;
  assign ic2l2_req_valid  = (state == ST_FILL_REQ);
  assign ic2l2_req_paddr  = req_paddr;
  assign ic_idle          = (state == ST_IDLE);

endmodule

// File: tb/tb_orv64_icache_resp.sv
// Self-checking bench for orv64_icache_resp: a directed vector table from the
// test plan, randomized requests against a line-level cache model, and
// hand-written reset/flush sequences.
module tb_orv64_icache_resp;
  import orv64_icache_resp_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              ib2ic_en;
  logic [38:0]       ib2ic_pc;
  logic              ic2ib_valid;
  logic [255:0]      ic2ib_rdata;
  logic              ic2ib_excp_valid;
  orv64_excp_cause_t ic2ib_excp_cause;
  logic [55:0]       ic2ib_pc_paddr;
  logic              l1_hit, l1_miss;
  logic              ic_flush;
  logic              ic2l2_req_valid;
  logic              ic2l2_req_ready;
  logic [55:0]       ic2l2_req_paddr;
  logic              l22ic_resp_valid;
  logic [255:0]      l22ic_resp_data;
  logic              l22ic_resp_err;
  logic              ic_idle;

  orv64_icache_resp #(
    .NUM_SETS(8), .LINE_WIDTH(256), .OFFSET_WIDTH(5), .VADDR_WIDTH(39), .PADDR_WIDTH(56)
  ) dut (
    .clk(clk), .rst(rst), .ib2ic_en(ib2ic_en), .ib2ic_pc(ib2ic_pc),
    .ic2ib_valid(ic2ib_valid), .ic2ib_rdata(ic2ib_rdata),
    .ic2ib_excp_valid(ic2ib_excp_valid), .ic2ib_excp_cause(ic2ib_excp_cause),
    .ic2ib_pc_paddr(ic2ib_pc_paddr), .l1_hit(l1_hit), .l1_miss(l1_miss),
    .ic_flush(ic_flush), .ic2l2_req_valid(ic2l2_req_valid),
    .ic2l2_req_ready(ic2l2_req_ready), .ic2l2_req_paddr(ic2l2_req_paddr),
    .l22ic_resp_valid(l22ic_resp_valid), .l22ic_resp_data(l22ic_resp_data),
    .l22ic_resp_err(l22ic_resp_err), .ic_idle(ic_idle)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Line-level cache model: each set remembers which line (pc >> 5) it holds.
  bit           m_valid [8];
  logic [33:0]  m_line  [8];
  logic [255:0] m_data  [8];

  function automatic int m_set(logic [38:0] pc);
    return int'((pc >> 5) % 8);
  endfunction

  function automatic bit m_hit(logic [38:0] pc);
    return m_valid[m_set(pc)] && (m_line[m_set(pc)] == 34'(pc >> 5));
  endfunction

  function automatic void m_clear();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  function automatic void chk(string nm, logic [255:0] act, logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  // Called #1 after a rising edge with the DUT idle. Drives one request
  // through the protocol on a fixed schedule and checks each cycle.
  task automatic do_req(input logic [38:0] pc, input bit exp_hit, input int rdly,
                        input int wdly, input bit err, input bit ffill, input bit fhit);
    logic [55:0]  exp_pa;
    logic [255:0] fdata;
    int           s;
    exp_pa = 56'(pc >> 5) << 5;
    fdata  = rand_line();
    s      = m_set(pc);
    ib2ic_en = 1'b1;
    ib2ic_pc = pc;
    @(posedge clk); #1;
    #1;
    if (exp_hit) begin
      chk("hit_valid", 256'(ic2ib_valid), 256'(1));
      chk("hit_l1_hit", 256'(l1_hit), 256'(1));
      chk("hit_l1_miss", 256'(l1_miss), 256'(0));
      chk("hit_rdata", ic2ib_rdata, m_data[s]);
      chk("hit_paddr", 256'(ic2ib_pc_paddr), 256'(exp_pa));
      chk("hit_excp", 256'(ic2ib_excp_valid), 256'(0));
      chk("hit_no_l2", 256'(ic2l2_req_valid), 256'(0));
      ic_flush = fhit;
      ib2ic_en = 1'b0;
      @(posedge clk); #1;
      ic_flush = 1'b0;
      if (fhit) m_clear();
    end else begin
      chk("lookup_no_resp", 256'(ic2ib_valid), 256'(0));
      chk("lookup_no_l2", 256'(ic2l2_req_valid), 256'(0));
      @(posedge clk); #1;
      for (int i = 0; i <= rdly; i++) begin
        ic2l2_req_ready = (i == rdly);
        #1;
        chk("req_valid", 256'(ic2l2_req_valid), 256'(1));
        chk("req_paddr", 256'(ic2l2_req_paddr), 256'(exp_pa));
        chk("req_no_resp", 256'(ic2ib_valid), 256'(0));
        @(posedge clk); #1;
      end
      ic2l2_req_ready = 1'b0;
      for (int i = 0; i < wdly; i++) begin
        ic_flush = ffill && (i == 0);
        #1;
        chk("wait_no_resp", 256'(ic2ib_valid), 256'(0));
        chk("wait_req_low", 256'(ic2l2_req_valid), 256'(0));
        @(posedge clk); #1;
        ic_flush = 1'b0;
      end
      l22ic_resp_valid = 1'b1;
      l22ic_resp_data  = fdata;
      l22ic_resp_err   = err;
      ic_flush         = ffill && (wdly == 0);
      #1;
      chk("fill_valid", 256'(ic2ib_valid), 256'(1));
      chk("fill_l1_miss", 256'(l1_miss), 256'(1));
      chk("fill_l1_hit", 256'(l1_hit), 256'(0));
      chk("fill_rdata", ic2ib_rdata, err ? 256'(0) : fdata);
      chk("fill_excp", 256'(ic2ib_excp_valid), 256'(err));
      chk("fill_cause", 256'(ic2ib_excp_cause),
          256'(err ? ORV64_EXCP_CAUSE_INST_ACCESS_FAULT : ORV64_EXCP_CAUSE_INST_ADDR_MISALIGNED));
      chk("fill_paddr", 256'(ic2ib_pc_paddr), 256'(exp_pa));
      ib2ic_en = 1'b0;
      @(posedge clk); #1;
      l22ic_resp_valid = 1'b0;
      l22ic_resp_err   = 1'b0;
      ic_flush         = 1'b0;
      if (ffill) begin
        m_clear();
      end else if (!err) begin
        m_valid[s] = 1'b1;
        m_line[s]  = 34'(pc >> 5);
        m_data[s]  = fdata;
      end
    end
    #1;
    chk("post_idle", 256'(ic_idle), 256'(1));
    chk("post_no_resp", 256'(ic2ib_valid), 256'(0));
  endtask

  typedef struct {
    logic [38:0] pc;
    bit          exp_hit;
    int          rdly;
    int          wdly;
    bit          err;
    bit          ffill;
    bit          fhit;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [38:0] saved [$];
    logic [38:0] pc;

    vecs[0]  = '{39'h1006, 1'b0, 5, 1, 1'b0, 1'b0, 1'b0};  // cold miss, ready low 5 cycles
    vecs[1]  = '{39'h101E, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0};  // same line hits
    vecs[2]  = '{39'h1100, 1'b0, 0, 2, 1'b0, 1'b0, 1'b0};  // conflict, same set
    vecs[3]  = '{39'h1000, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0};  // evicted, misses again
    vecs[4]  = '{39'h2000, 1'b0, 0, 1, 1'b1, 1'b0, 1'b0};  // bus error
    vecs[5]  = '{39'h2000, 1'b0, 2, 0, 1'b0, 1'b0, 1'b0};  // error line was not kept
    vecs[6]  = '{39'h3000, 1'b0, 0, 1, 1'b0, 1'b1, 1'b0};  // flush during fill wait
    vecs[7]  = '{39'h3000, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};  // flushed fill not kept
    vecs[8]  = '{39'h3010, 1'b1, 0, 0, 1'b0, 1'b0, 1'b1};  // flush in hit cycle
    vecs[9]  = '{39'h3000, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};  // misses after that flush
    vecs[10] = '{39'h1020, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};  // another set
    vecs[11] = '{39'h103F, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0};  // last byte of that line
    vecs[12] = '{39'h3004, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0};  // set 0 still holds 0x3000

    rst = 1'b1; ib2ic_en = 1'b0; ib2ic_pc = '0; ic_flush = 1'b0;
    ic2l2_req_ready = 1'b0; l22ic_resp_valid = 1'b0; l22ic_resp_data = '0; l22ic_resp_err = 1'b0;
    m_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 256'(ic2ib_valid), 256'(0));
    chk("rst_l1_hit", 256'(l1_hit), 256'(0));
    chk("rst_l1_miss", 256'(l1_miss), 256'(0));
    chk("rst_req_valid", 256'(ic2l2_req_valid), 256'(0));
    chk("rst_excp", 256'(ic2ib_excp_valid), 256'(0));
    chk("rst_idle", 256'(ic_idle), 256'(1));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 13; v++)
      do_req(vecs[v].pc, vecs[v].exp_hit, vecs[v].rdly, vecs[v].wdly,
             vecs[v].err, vecs[v].ffill, vecs[v].fhit);

    for (int n = 0; n < 80; n++) begin
      pc = 39'(($urandom_range(0, 3) << 13) | ($urandom_range(0, 7) << 5) | $urandom_range(0, 31));
      do_req(pc, m_hit(pc), $urandom_range(0, 3), $urandom_range(0, 3),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

    // Make sure a few lines are resident, then reset in the middle of a fill.
    for (int s = 0; s < 3; s++) begin
      pc = 39'(32'h6000 + 32'(s * 32));
      do_req(pc, m_hit(pc), 0, 0, 1'b0, 1'b0, 1'b0);
    end
    for (int s = 0; s < 8; s++)
      if (m_valid[s]) saved.push_back(39'(m_line[s]) << 5);

    ib2ic_en = 1'b1;
    ib2ic_pc = 39'h40_0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    ic2l2_req_ready = 1'b1;
    #1;
    chk("rstfill_req_valid", 256'(ic2l2_req_valid), 256'(1));
    @(posedge clk); #1;
    ic2l2_req_ready = 1'b0;
    #1;
    chk("rstfill_busy", 256'(ic_idle), 256'(0));
    rst = 1'b1;
    ib2ic_en = 1'b0;
    @(posedge clk); #1;
    chk("rstfill_idle", 256'(ic_idle), 256'(1));
    chk("rstfill_req_low", 256'(ic2l2_req_valid), 256'(0));
    chk("rstfill_no_resp", 256'(ic2ib_valid), 256'(0));
    rst = 1'b0;
    m_clear();
    @(posedge clk); #1;
    foreach (saved[i]) do_req(saved[i], 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
